// File: rtl/apb_chip_ctrl_arb_pkg.sv
// Shared types and constants for the chip-control APB arbiter.
// Holds the FSM state encoding, requester indices and the default wait limit.
package apb_chip_ctrl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam logic REQ_FC  = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS wait-cycle counter with terminal-count compare.
// LIMIT of 0 never reports a hit.
module apb_timeout_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic soc_clk_i,
  input  logic soc_rst_i,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge soc_clk_i) begin
    if (soc_rst_i || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = (LIMIT != 0) && (cnt_q == LIMIT_W);

endmodule

// File: rtl/apb_chip_ctrl_arbiter.sv
// Two-requester APB arbiter (FC/SoC bus and JTAG/debug) onto the chip-control APB,
// with round-robin grant and an ACCESS wait-cycle timeout.
//
//   state  | meaning
//   IDLE   | no transfer; arbitrate among pending requesters
//   SETUP  | master psel=1, penable=0 for the granted requester
//   ACCESS | master psel=1, penable=1; wait for pready or timeout
module apb_chip_ctrl_arbiter
  import apb_chip_ctrl_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                 soc_clk_i,
  input  logic                                 soc_rst_i,
  input  logic [1:0][ADDR_WIDTH-1:0]           s_paddr_i,
  input  logic [1:0][2:0]                      s_pprot_i,
  input  logic [1:0]                           s_psel_i,
  input  logic [1:0]                           s_penable_i,
  input  logic [1:0]                           s_pwrite_i,
  input  logic [1:0][DATA_WIDTH-1:0]           s_pwdata_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]         s_pstrb_i,
  output logic [1:0][DATA_WIDTH-1:0]           s_prdata_o,
  output logic [1:0]                           s_pready_o,
  output logic [1:0]                           s_pslverr_o,
  output logic [ADDR_WIDTH-1:0]                m_paddr_o,
  output logic [2:0]                           m_pprot_o,
  output logic                                 m_psel_o,
  output logic                                 m_penable_o,
  output logic                                 m_pwrite_o,
  output logic [DATA_WIDTH-1:0]                m_pwdata_o,
  output logic [DATA_WIDTH/8-1:0]              m_pstrb_o,
  input  logic [DATA_WIDTH-1:0]                m_prdata_i,
  input  logic                                 m_pready_i,
  input  logic                                 m_pslverr_i,
  output logic                                 timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e state_q, state_n;
  logic       grant_q, grant_n;
  logic       cnt_clear, cnt_en, cnt_hit;
  logic       unused_penable;

  // Requester penable carries no information the arbiter needs; grant is held by state.
  assign unused_penable = ^s_penable_i;

  apb_timeout_cnt #(
    .WIDTH (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .soc_clk_i (soc_clk_i),
    .soc_rst_i (soc_rst_i),
    .clear     (cnt_clear),
    .enable    (cnt_en),
    .hit       (cnt_hit)
  );

  // grant_q doubles as the round-robin last-grant pointer.
  always_ff @(posedge soc_clk_i) begin
    if (soc_rst_i) begin
      state_q <= IDLE;
      grant_q <= REQ_DBG;
    end else begin
      state_q <= state_n;
      if ((state_q == IDLE) && (|s_psel_i)) begin
        grant_q <= grant_n;
      end
    end
  end

  always_comb begin
    state_n     = state_q;
    grant_n     = grant_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    m_paddr_o   = '0;
    m_pprot_o   = '0;
    m_psel_o    = 1'b0;
    m_penable_o = 1'b0;
    m_pwrite_o  = 1'b0;
    m_pwdata_o  = '0;
    m_pstrb_o   = '0;
    s_prdata_o  = '0;
    s_pready_o  = '0;
    s_pslverr_o = '0;
    timeout_o   = 1'b0;

    case (s_psel_i)
      2'b01:   grant_n = REQ_FC;
      2'b10:   grant_n = REQ_DBG;
      2'b11:   grant_n = ~grant_q;
      default: grant_n = grant_q;
    endcase

    case (state_q)
      IDLE: begin
        if (|s_psel_i) state_n = SETUP;
      end
      SETUP: begin
        state_n   = ACCESS;
        cnt_clear = 1'b1;
      end
      ACCESS: begin
        if (m_pready_i) begin
          state_n = IDLE;
          // A reset landing on the completing cycle must not leak a response.
          if (!soc_rst_i) begin
            s_pready_o[grant_q]  = 1'b1;
            s_prdata_o[grant_q]  = m_prdata_i;
            s_pslverr_o[grant_q] = m_pslverr_i;
          end
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            state_n = IDLE;
            if (!soc_rst_i) begin
              s_pready_o[grant_q]  = 1'b1;
              s_pslverr_o[grant_q] = 1'b1;
              timeout_o            = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_q != IDLE) begin
      m_psel_o    = 1'b1;
      m_penable_o = (state_q == ACCESS);
      m_paddr_o   = s_paddr_i[grant_q];
      m_pprot_o   = s_pprot_i[grant_q];
      m_pwrite_o  = s_pwrite_i[grant_q];
      m_pwdata_o  = s_pwdata_i[grant_q];
      m_pstrb_o   = s_pstrb_i[grant_q];
    end
  end

endmodule
